pc_sequencer: RTL and testbench

//  Parametrised next-PC unit for the MIPS fetch stage. It generalises the 32-bit PC controller.

---
 rtl/pc_sequencer_pkg.sv | 33 +++
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer_ras.sv | 55 +++++
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the next-PC sequencer: FSM states,
// target-source selection and the sequential PC increment.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        SEL_RET,
        SEL_JR,
        SEL_JMP,
        SEL_BR,
        SEL_SEQ
    } sel_t;

    localparam int PC_INC = 4;

    // Fixed priority: return, register jump, J-type (jal or jump), branch, sequential.
    function automatic sel_t pick_source(input logic ret, input logic jr,
                                         input logic jmp, input logic beq);
        sel_t sel;
        if (ret)      sel = SEL_RET;
        else if (jr)  sel = SEL_JR;
        else if (jmp) sel = SEL_JMP;
        else if (beq) sel = SEL_BR;
        else          sel = SEL_SEQ;
        return sel;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Start/finish handshake and control/address bundle between decode and
// the next-PC sequencer.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic              beq;
    logic              jump;
    logic              jal;
    logic              jr;
    logic              ret;
    logic [ADDR_W-1:0] branch_offset;
    logic [25:0]       jump_addr;
    logic [ADDR_W-1:0] jr_addr;
    logic [ADDR_W-1:0] pc;
    logic              finish;
    logic              ready;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_err;

    modport master (
        output start, beq, jump, jal, jr, ret, branch_offset, jump_addr, jr_addr,
        input  pc, finish, ready, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  start, beq, jump, jal, jr, ret, branch_offset, jump_addr, jr_addr,
        output pc, finish, ready, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty is dropped; both raise a sticky error flag.
module pc_ras #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_top,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_err
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_err;
    logic [PTR_W-1:0] w_top_ptr;

    assign w_top_ptr = r_wr_ptr - PTR_W'(1);
    assign o_top     = r_mem[w_top_ptr];
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_err     = r_err;

    // NOTE: storage has no reset; the entry count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else if (i_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (o_full) r_err   <= 1'b1;
            else        r_count <= r_count + (PTR_W + 1)'(1);
        end else if (i_pop) begin
            if (o_empty) begin
                r_err <= 1'b1;
            end else begin
                r_wr_ptr <= w_top_ptr;
                r_count  <= r_count - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC unit: latches one request per start, computes the target in CALC,
// and pulses finish in DONE; return addresses live in a pc_ras instance.
module pc_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                RAS_DEPTH    = 8
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    import pc_seq_pkg::*;

    localparam logic [ADDR_W-1:0] SEG_MASK = ADDR_W'(28'hFFF_FFFF);

    state_t            r_state, w_state_nxt;
    logic              w_accept;
    logic [ADDR_W-1:0] r_pc;
    logic              r_beq, r_jump, r_jal, r_jr, r_ret;
    logic [ADDR_W-1:0] r_offset, r_jr_addr;
    logic [25:0]       r_jump_addr;
    sel_t              w_sel;
    logic [ADDR_W-1:0] w_pc4, w_target, w_ras_top;
    logic              w_push, w_pop, w_ras_empty, w_ras_full, w_ras_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        bus.ready   = 1'b1;
        bus.finish  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept    = bus.start;
                w_state_nxt = bus.start ? ST_CALC : ST_IDLE;
            end
            ST_CALC: begin
                bus.ready   = 1'b0;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.finish  = 1'b1;
                w_accept    = bus.start;
                w_state_nxt = bus.start ? ST_CALC : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so all state updates on an edge see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {r_beq, r_jump, r_jal, r_jr, r_ret} <= '0;
            r_offset    <= '0;
            r_jr_addr   <= '0;
            r_jump_addr <= '0;
        end else if (w_accept) begin
            {r_beq, r_jump, r_jal, r_jr, r_ret} <=
                {bus.beq, bus.jump, bus.jal, bus.jr, bus.ret};
            r_offset    <= bus.branch_offset;
            r_jr_addr   <= bus.jr_addr;
            r_jump_addr <= bus.jump_addr;
        end
    end

    always_comb begin
        w_sel    = pick_source(r_ret, r_jr, r_jal | r_jump, r_beq);
        w_pc4    = r_pc + ADDR_W'(PC_INC);
        w_target = w_pc4;
        case (w_sel)
            SEL_RET: w_target = w_ras_empty ? w_pc4 : w_ras_top;
            SEL_JR:  w_target = {r_jr_addr[ADDR_W-1:2], 2'b00};
            SEL_JMP: w_target = (w_pc4 & ~SEG_MASK) | ADDR_W'({r_jump_addr, 2'b00});
            SEL_BR:  w_target = w_pc4 + (r_offset << 2);
            default: w_target = w_pc4;
        endcase
    end

    assign w_push = (r_state == ST_CALC) && (w_sel == SEL_JMP) && r_jal;
    assign w_pop  = (r_state == ST_CALC) && (w_sel == SEL_RET);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    r_pc <= RESET_VECTOR;
        else if (r_state == ST_CALC)  r_pc <= w_target;
    end

    pc_ras #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_pc4),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_full  (w_ras_full),
        .o_err   (w_ras_err)
    );

    assign bus.pc        = r_pc;
    assign bus.ras_empty = w_ras_empty;
    assign bus.ras_full  = w_ras_full;
    assign bus.ras_err   = w_ras_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// handshake/reset sequences, and random requests against a stack-based model.
module tb_pc_sequencer;

    localparam int DEPTH = 4;

    typedef struct {
        logic        beq, jump, jal, jr, ret;
        logic [31:0] off;
        logic [25:0] jaddr;
        logic [31:0] jraddr;
        logic [31:0] exp_pc;
        logic        exp_empty, exp_full, exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(32)) bus1 ();
    pc_sequencer_if #(.ADDR_W(40)) bus2 ();

    pc_sequencer #(.ADDR_W(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    pc_sequencer #(.ADDR_W(40), .RESET_VECTOR(40'h400), .RAS_DEPTH(DEPTH)) dut40 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    // Reference model state: PC, return stack (back = newest), sticky error.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic        m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input vec_t vin, output vec_t vout);
        logic [31:0] pc4;
        logic [31:0] tgt;
        vout = vin;
        pc4  = m_pc + 32'd4;
        if (vin.ret) begin
            if (m_q.size() > 0) tgt = m_q.pop_back();
            else begin tgt = pc4; m_err = 1'b1; end
        end else if (vin.jr) begin
            tgt = vin.jraddr & ~32'd3;
        end else if (vin.jal || vin.jump) begin
            tgt = (pc4 & 32'hF000_0000) | ({6'd0, vin.jaddr} * 32'd4);
            if (vin.jal) begin
                if (m_q.size() == DEPTH) begin
                    void'(m_q.pop_front());
                    m_err = 1'b1;
                end
                m_q.push_back(pc4);
            end
        end else if (vin.beq) begin
            tgt = pc4 + vin.off * 32'd4;
        end else begin
            tgt = pc4;
        end
        m_pc           = tgt;
        vout.exp_pc    = tgt;
        vout.exp_empty = (m_q.size() == 0);
        vout.exp_full  = (m_q.size() == DEPTH);
        vout.exp_err   = m_err;
    endtask

    task automatic idle_inputs();
        bus1.start = 0; bus1.beq = 0; bus1.jump = 0; bus1.jal = 0; bus1.jr = 0; bus1.ret = 0;
        bus1.branch_offset = '0; bus1.jump_addr = '0; bus1.jr_addr = '0;
        bus2.start = 0; bus2.beq = 0; bus2.jump = 0; bus2.jal = 0; bus2.jr = 0; bus2.ret = 0;
        bus2.branch_offset = '0; bus2.jump_addr = '0; bus2.jr_addr = '0;
    endtask

    task automatic do_update(input vec_t v, input string tag);
        @(negedge clk);
        bus1.beq = v.beq; bus1.jump = v.jump; bus1.jal = v.jal; bus1.jr = v.jr; bus1.ret = v.ret;
        bus1.branch_offset = v.off; bus1.jump_addr = v.jaddr; bus1.jr_addr = v.jraddr;
        bus1.start = 1'b1;
        @(posedge clk); #1;
        check({tag, " ready_in_calc"}, bus1.ready, 1'b0);
        check({tag, " finish_in_calc"}, bus1.finish, 1'b0);
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        check({tag, " pc"}, bus1.pc, v.exp_pc);
        check({tag, " finish_in_done"}, bus1.finish, 1'b1);
        check({tag, " ready_in_done"}, bus1.ready, 1'b1);
        check({tag, " ras_empty"}, bus1.ras_empty, v.exp_empty);
        check({tag, " ras_full"}, bus1.ras_full, v.exp_full);
        check({tag, " ras_err"}, bus1.ras_err, v.exp_err);
        @(posedge clk); #1;
        check({tag, " finish_after_done"}, bus1.finish, 1'b0);
    endtask

    task automatic do_update40(input logic jr, input logic [39:0] jraddr,
                               input logic [39:0] exp_pc, input string tag);
        @(negedge clk);
        bus2.jr = jr; bus2.jr_addr = jraddr; bus2.start = 1'b1;
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        check({tag, " pc40"}, bus2.pc, exp_pc);
        check({tag, " finish40"}, bus2.finish, 1'b1);
        @(posedge clk); #1;
    endtask

    vec_t tbl[20];
    vec_t rv, rexp;
    int   pulses;

    initial begin
        tbl[0]  = '{0,0,0,0,0, 32'd0,          26'd0,    32'd0,          32'd4,          1,0,0};
        tbl[1]  = '{1,0,0,0,0, 32'd2000,       26'd0,    32'd0,          32'd8008,       1,0,0};
        tbl[2]  = '{1,0,0,0,0, 32'hFFFF_FFFE,  26'd0,    32'd0,          32'd8004,       1,0,0};
        tbl[3]  = '{0,1,0,0,0, 32'd0,          26'd1000, 32'd0,          32'd4000,       1,0,0};
        tbl[4]  = '{1,1,0,0,0, 32'd100,        26'd1000, 32'd0,          32'd4000,       1,0,0};
        tbl[5]  = '{0,0,1,0,0, 32'd0,          26'd250,  32'd0,          32'd1000,       0,0,0};
        tbl[6]  = '{0,0,0,0,1, 32'd0,          26'd0,    32'd0,          32'd4004,       1,0,0};
        tbl[7]  = '{0,0,1,0,0, 32'd0,          26'd100,  32'd0,          32'd400,        0,0,0};
        tbl[8]  = '{0,0,1,0,0, 32'd0,          26'd200,  32'd0,          32'd800,        0,0,0};
        tbl[9]  = '{0,0,1,0,0, 32'd0,          26'd300,  32'd0,          32'd1200,       0,0,0};
        tbl[10] = '{0,0,1,0,0, 32'd0,          26'd400,  32'd0,          32'd1600,       0,1,0};
        tbl[11] = '{0,0,1,0,0, 32'd0,          26'd500,  32'd0,          32'd2000,       0,1,1};
        tbl[12] = '{0,0,0,0,1, 32'd0,          26'd0,    32'd0,          32'd1604,       0,0,1};
        tbl[13] = '{0,0,0,0,1, 32'd0,          26'd0,    32'd0,          32'd1204,       0,0,1};
        tbl[14] = '{0,0,0,0,1, 32'd0,          26'd0,    32'd0,          32'd804,        0,0,1};
        tbl[15] = '{0,0,0,0,1, 32'd0,          26'd0,    32'd0,          32'd404,        1,0,1};
        tbl[16] = '{0,0,0,0,1, 32'd0,          26'd0,    32'd0,          32'd408,        1,0,1};
        tbl[17] = '{0,0,1,1,0, 32'd0,          26'd9,    32'h1234_5677,  32'h1234_5674,  1,0,1};
        tbl[18] = '{0,1,0,0,0, 32'd0,          26'd5,    32'd0,          32'h1000_0014,  1,0,1};
        tbl[19] = '{0,0,1,0,1, 32'd0,          26'd7,    32'd0,          32'h1000_0018,  1,0,1};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset pc", bus1.pc, 32'h0);
        check("reset ready", bus1.ready, 1'b1);
        check("reset finish", bus1.finish, 1'b0);
        check("reset ras_empty", bus1.ras_empty, 1'b1);
        check("reset ras_full", bus1.ras_full, 1'b0);
        check("reset ras_err", bus1.ras_err, 1'b0);
        check("reset pc40", bus2.pc, 40'h400);

        do_update40(1'b1, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFC, "w40 jr");
        do_update40(1'b0, 40'h0,            40'h0,            "w40 wrap");

        for (int i = 0; i < 20; i++) begin
            do_update(tbl[i], $sformatf("vec%0d", i));
        end

        // Start held through CALC is ignored; start in DONE chains a second update.
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk); #1;
        check("b2b ready_calc1", bus1.ready, 1'b0);
        @(posedge clk); #1;
        check("b2b pc1", bus1.pc, 32'h1000_001C);
        check("b2b finish1", bus1.finish, 1'b1);
        @(posedge clk); #1;
        check("b2b ready_calc2", bus1.ready, 1'b0);
        check("b2b finish_calc2", bus1.finish, 1'b0);
        @(negedge clk);
        bus1.start = 1'b0;
        @(posedge clk); #1;
        check("b2b pc2", bus1.pc, 32'h1000_0020);
        check("b2b finish2", bus1.finish, 1'b1);
        @(posedge clk); #1;
        check("b2b idle finish", bus1.finish, 1'b0);
        @(posedge clk); #1;
        check("b2b no queued update", bus1.pc, 32'h1000_0020);

        tbl[0] = '{0,0,1,0,0, 32'd0, 26'd3, 32'd0, 32'h1000_000C, 0,0,1};
        do_update(tbl[0], "pre-abort jal");

        // Reset asserted while a return is in CALC must abort it cleanly.
        @(negedge clk);
        bus1.ret = 1'b1; bus1.start = 1'b1;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("abort pc", bus1.pc, 32'h0);
        check("abort ready", bus1.ready, 1'b1);
        check("abort finish", bus1.finish, 1'b0);
        check("abort ras_empty", bus1.ras_empty, 1'b1);
        check("abort ras_err", bus1.ras_err, 1'b0);
        check("abort pc40", bus2.pc, 40'h400);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus1.finish) pulses++;
        end
        check("abort finish pulses", pulses, 0);
        check("abort pc held", bus1.pc, 32'h0);

        m_pc  = 32'h0;
        m_q.delete();
        m_err = 1'b0;
        for (int i = 0; i < 150; i++) begin
            rv.beq    = ($urandom_range(0, 3) == 0);
            rv.jump   = ($urandom_range(0, 5) == 0);
            rv.jal    = ($urandom_range(0, 3) == 0);
            rv.jr     = ($urandom_range(0, 7) == 0);
            rv.ret    = ($urandom_range(0, 3) == 0);
            rv.off    = 32'($urandom_range(0, 4000)) - 32'd2000;
            rv.jaddr  = 26'($urandom);
            rv.jraddr = $urandom;
            model_step(rv, rexp);
            do_update(rexp, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
